// File: rtl/bumpy_collision_detector.sv
// Frame-based Bumpy/brick collision detector: accumulates overlap over a frame, presents it for the next.
// Optional macro HITEDGE_FILTER_EN: per-edge pixel counters with a MIN_EDGE_PIXELS threshold.
module bumpy_collision_detector #(
    parameter int unsigned SPRITE_SIZE     = 32,
    parameter int unsigned EDGE_WIDTH      = 4
`ifdef HITEDGE_FILTER_EN
    ,
    parameter int unsigned MIN_EDGE_PIXELS = 3
`endif
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        bumpyDrawingRequest,
    input  logic        brickDrawingRequest,
    input  logic        jumpBrickDrawingRequest,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        EndGame,
    output logic        collision,
    output logic        jumpCollision,
    output logic [3:0]  HitEdgeCode,
    output logic [11:0] hitPixelCount
);

    localparam int unsigned OFF_W  = 13;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned EDGE_N = 4;
`ifdef HITEDGE_FILTER_EN
    localparam int unsigned ECNT_W = 6;
`endif

    typedef enum logic {WAIT_SOF, ACCUM} state_e;

    state_e             state_q, state_d;
    logic               acc_brick_q, acc_brick_d;
    logic               acc_jump_q, acc_jump_d;
    logic [CNT_W-1:0]   acc_count_q, acc_count_d;
    logic               collision_q, collision_d;
    logic               jump_collision_q, jump_collision_d;
    logic [EDGE_N-1:0]  hit_edge_q, hit_edge_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
`ifdef HITEDGE_FILTER_EN
    logic [EDGE_N-1:0][ECNT_W-1:0] edge_cnt_q, edge_cnt_d;
`else
    logic [EDGE_N-1:0]  acc_edge_q, acc_edge_d;
`endif

    logic                    brick_hit_c, jump_hit_c, overlap_c;
    logic signed [OFF_W-1:0] off_x_c, off_y_c;
    logic                    in_box_c;
    logic [EDGE_N-1:0]       edge_hit_c;

    // One extra bit beyond 12 keeps pixel minus a negative top-left from wrapping.
    assign off_x_c = $signed({2'b00, pixelX}) - $signed({{2{topLeftX[10]}}, topLeftX});
    assign off_y_c = $signed({2'b00, pixelY}) - $signed({{2{topLeftY[10]}}, topLeftY});

    assign brick_hit_c = bumpyDrawingRequest & brickDrawingRequest;
    assign jump_hit_c  = bumpyDrawingRequest & jumpBrickDrawingRequest;
    assign overlap_c   = brick_hit_c | jump_hit_c;

    assign in_box_c = !off_x_c[OFF_W-1] && !off_y_c[OFF_W-1]
                   && ($unsigned(off_x_c) < OFF_W'(SPRITE_SIZE))
                   && ($unsigned(off_y_c) < OFF_W'(SPRITE_SIZE));

    // Edge bands: bit0 bottom, bit1 right, bit2 top, bit3 left.
    always_comb begin
        edge_hit_c    = '0;
        edge_hit_c[0] = $unsigned(off_y_c) >= OFF_W'(SPRITE_SIZE - EDGE_WIDTH);
        edge_hit_c[1] = $unsigned(off_x_c) >= OFF_W'(SPRITE_SIZE - EDGE_WIDTH);
        edge_hit_c[2] = $unsigned(off_y_c) <  OFF_W'(EDGE_WIDTH);
        edge_hit_c[3] = $unsigned(off_x_c) <  OFF_W'(EDGE_WIDTH);
        edge_hit_c    = edge_hit_c & {EDGE_N{in_box_c & overlap_c}};
    end

    always_comb begin
        state_d          = state_q;
        acc_brick_d      = acc_brick_q;
        acc_jump_d       = acc_jump_q;
        acc_count_d      = acc_count_q;
        collision_d      = collision_q;
        jump_collision_d = jump_collision_q;
        hit_edge_d       = hit_edge_q;
        hit_count_d      = hit_count_q;
`ifdef HITEDGE_FILTER_EN
        edge_cnt_d       = edge_cnt_q;
`else
        acc_edge_d       = acc_edge_q;
`endif
        if (EndGame) begin
            state_d          = WAIT_SOF;
            acc_brick_d      = 1'b0;
            acc_jump_d       = 1'b0;
            acc_count_d      = '0;
            collision_d      = 1'b0;
            jump_collision_d = 1'b0;
            hit_edge_d       = '0;
            hit_count_d      = '0;
`ifdef HITEDGE_FILTER_EN
            edge_cnt_d       = '0;
`else
            acc_edge_d       = '0;
`endif
        end else begin
            case (state_q)
                WAIT_SOF: begin
                    if (startOfFrame) state_d = ACCUM;
                end
                ACCUM: begin
                    if (startOfFrame) begin
                        // Commit the finished frame; the coincident pixel seeds the new one.
                        collision_d      = acc_brick_q | acc_jump_q;
                        jump_collision_d = acc_jump_q;
                        hit_count_d      = acc_count_q;
                        acc_brick_d      = brick_hit_c;
                        acc_jump_d       = jump_hit_c;
                        acc_count_d      = CNT_W'(overlap_c);
`ifdef HITEDGE_FILTER_EN
                        for (int i = 0; i < int'(EDGE_N); i++) begin
                            hit_edge_d[i] = edge_cnt_q[i] >= ECNT_W'(MIN_EDGE_PIXELS);
                            edge_cnt_d[i] = ECNT_W'(edge_hit_c[i]);
                        end
`else
                        hit_edge_d       = acc_edge_q;
                        acc_edge_d       = edge_hit_c;
`endif
                    end else begin
                        acc_brick_d = acc_brick_q | brick_hit_c;
                        acc_jump_d  = acc_jump_q | jump_hit_c;
                        if (overlap_c && (acc_count_q != {CNT_W{1'b1}}))
                            acc_count_d = acc_count_q + CNT_W'(1);
`ifdef HITEDGE_FILTER_EN
                        for (int i = 0; i < int'(EDGE_N); i++) begin
                            if (edge_hit_c[i] && (edge_cnt_q[i] != {ECNT_W{1'b1}}))
                                edge_cnt_d[i] = edge_cnt_q[i] + ECNT_W'(1);
                        end
`else
                        acc_edge_d  = acc_edge_q | edge_hit_c;
`endif
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= WAIT_SOF;
            acc_brick_q      <= 1'b0;
            acc_jump_q       <= 1'b0;
            acc_count_q      <= '0;
            collision_q      <= 1'b0;
            jump_collision_q <= 1'b0;
            hit_edge_q       <= '0;
            hit_count_q      <= '0;
`ifdef HITEDGE_FILTER_EN
            edge_cnt_q       <= '0;
`else
            acc_edge_q       <= '0;
`endif
        end else begin
            state_q          <= state_d;
            acc_brick_q      <= acc_brick_d;
            acc_jump_q       <= acc_jump_d;
            acc_count_q      <= acc_count_d;
            collision_q      <= collision_d;
            jump_collision_q <= jump_collision_d;
            hit_edge_q       <= hit_edge_d;
            hit_count_q      <= hit_count_d;
`ifdef HITEDGE_FILTER_EN
            edge_cnt_q       <= edge_cnt_d;
`else
            acc_edge_q       <= acc_edge_d;
`endif
        end
    end

    assign collision     = collision_q;
    assign jumpCollision = jump_collision_q;
    assign HitEdgeCode   = hit_edge_q;
    assign hitPixelCount = hit_count_q;

endmodule

// File: tb/tb_bumpy_collision_detector.sv
// Directed self-checking bench for bumpy_collision_detector (default and HITEDGE_FILTER_EN builds).
module tb_bumpy_collision_detector;

`ifdef HITEDGE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic        bumpyDrawingRequest, brickDrawingRequest, jumpBrickDrawingRequest;
    logic [10:0] topLeftX, topLeftY;
    logic        EndGame;
    logic        collision, jumpCollision;
    logic [3:0]  HitEdgeCode;
    logic [11:0] hitPixelCount;

    int checks   = 0;
    int failures = 0;

    bumpy_collision_detector dut (
        .clk                     (clk),
        .resetN                  (resetN),
        .startOfFrame            (startOfFrame),
        .pixelX                  (pixelX),
        .pixelY                  (pixelY),
        .bumpyDrawingRequest     (bumpyDrawingRequest),
        .brickDrawingRequest     (brickDrawingRequest),
        .jumpBrickDrawingRequest (jumpBrickDrawingRequest),
        .topLeftX                (topLeftX),
        .topLeftY                (topLeftY),
        .EndGame                 (EndGame),
        .collision               (collision),
        .jumpCollision           (jumpCollision),
        .HitEdgeCode             (HitEdgeCode),
        .hitPixelCount           (hitPixelCount)
    );

    always #5 clk = ~clk;

    // Present one pixel for one clock, then sample #1 after the edge.
    task automatic drive(input int x, input int y, input logic bm, input logic br,
                         input logic jb, input logic sof);
        pixelX = 11'(x); pixelY = 11'(y);
        bumpyDrawingRequest = bm; brickDrawingRequest = br;
        jumpBrickDrawingRequest = jb; startOfFrame = sof;
        @(posedge clk); #1;
        bumpyDrawingRequest = 1'b0; brickDrawingRequest = 1'b0;
        jumpBrickDrawingRequest = 1'b0; startOfFrame = 1'b0;
    endtask

    task automatic sof();
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; EndGame = 1'b0;
        pixelX = '0; pixelY = '0; topLeftX = 11'd104; topLeftY = 11'd104;
        bumpyDrawingRequest = 1'b0; brickDrawingRequest = 1'b0; jumpBrickDrawingRequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_collision got=%0b exp=0", collision); end
        checks++; if (jumpCollision !== 1'b0) begin failures++; $display("FAIL reset_jump got=%0b exp=0", jumpCollision); end
        checks++; if (HitEdgeCode !== 4'b0000) begin failures++; $display("FAIL reset_edge got=%b exp=0000", HitEdgeCode); end
        checks++; if (hitPixelCount !== 12'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", hitPixelCount); end
        resetN = 1'b1;
        idle(2);
    endtask

    task automatic test_bottom_landing();
        // Pixels drawn before the arming SOF are ignored.
        drive(110, 134, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (collision !== 1'b0) begin failures++; $display("FAIL arm_no_commit got=%0b exp=0", collision); end
        for (int y = 134; y <= 135; y++)
            for (int x = 110; x <= 119; x++) drive(x, y, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(50, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        sof();
        checks++; if (collision !== 1'b1) begin failures++; $display("FAIL bottom_collision got=%0b exp=1", collision); end
        checks++; if (jumpCollision !== 1'b0) begin failures++; $display("FAIL bottom_jump got=%0b exp=0", jumpCollision); end
        checks++; if (HitEdgeCode !== 4'b0001) begin failures++; $display("FAIL bottom_edge got=%b exp=0001", HitEdgeCode); end
        checks++; if (hitPixelCount !== 12'd20) begin failures++; $display("FAIL bottom_count got=%0d exp=20", hitPixelCount); end
        drive(135, 104, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        checks++; if (hitPixelCount !== 12'd20 || HitEdgeCode !== 4'b0001) begin
            failures++; $display("FAIL bottom_hold got=%0d/%b exp=20/0001", hitPixelCount, HitEdgeCode); end
    endtask

    task automatic test_corner();
        sof();
        drive(135, 104, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (HitEdgeCode !== (FILT ? 4'b0000 : 4'b0110)) begin
            failures++; $display("FAIL corner_edge got=%b exp=%b", HitEdgeCode, FILT ? 4'b0000 : 4'b0110); end
        checks++; if (collision !== 1'b1) begin failures++; $display("FAIL corner_collision got=%0b exp=1", collision); end
        checks++; if (hitPixelCount !== 12'd1) begin failures++; $display("FAIL corner_count got=%0d exp=1", hitPixelCount); end
    endtask

    task automatic test_jump();
        for (int x = 104; x <= 107; x++) drive(x, 120, 1'b1, 1'b0, 1'b1, 1'b0);
        sof();
        checks++; if (jumpCollision !== 1'b1) begin failures++; $display("FAIL jump_jump got=%0b exp=1", jumpCollision); end
        checks++; if (collision !== 1'b1) begin failures++; $display("FAIL jump_collision got=%0b exp=1", collision); end
        checks++; if (HitEdgeCode !== 4'b1000) begin failures++; $display("FAIL jump_edge got=%b exp=1000", HitEdgeCode); end
        checks++; if (hitPixelCount !== 12'd4) begin failures++; $display("FAIL jump_count got=%0d exp=4", hitPixelCount); end
    endtask

    task automatic test_sof_coincidence();
        sof();
        idle(3);
        drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (collision !== 1'b0) begin failures++; $display("FAIL coinc_first got=%0b exp=0", collision); end
        idle(3);
        sof();
        checks++; if (collision !== 1'b1) begin failures++; $display("FAIL coinc_second got=%0b exp=1", collision); end
        checks++; if (hitPixelCount !== 12'd1) begin failures++; $display("FAIL coinc_count got=%0d exp=1", hitPixelCount); end
    endtask

    task automatic test_negative_topleft();
        // topLeftX = -8: pixel x=20 is offset 28 (right band), x=30 is offset 38 (outside).
        topLeftX = 11'h7F8; topLeftY = 11'd0;
        drive(20, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(30, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (HitEdgeCode !== (FILT ? 4'b0000 : 4'b0010)) begin
            failures++; $display("FAIL neg_edge got=%b exp=%b", HitEdgeCode, FILT ? 4'b0000 : 4'b0010); end
        checks++; if (hitPixelCount !== 12'd2) begin failures++; $display("FAIL neg_count got=%0d exp=2", hitPixelCount); end
        // Offset -1 on X is outside the box even though it touches the left column.
        topLeftX = 11'd200; topLeftY = 11'd200;
        drive(199, 210, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (HitEdgeCode !== 4'b0000 || collision !== 1'b1) begin
            failures++; $display("FAIL outbox got=%b/%0b exp=0000/1", HitEdgeCode, collision); end
        topLeftX = 11'd104; topLeftY = 11'd104;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4100; i++) drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (hitPixelCount !== 12'd4095) begin failures++; $display("FAIL sat_count got=%0d exp=4095", hitPixelCount); end
        checks++; if (HitEdgeCode !== 4'b0000) begin failures++; $display("FAIL sat_edge got=%b exp=0000", HitEdgeCode); end
    endtask

    task automatic test_endgame();
        drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b0);
        EndGame = 1'b1;
        @(posedge clk); #1;
        EndGame = 1'b0;
        checks++; if ({collision, jumpCollision, HitEdgeCode, hitPixelCount} !== 18'd0) begin
            failures++; $display("FAIL endgame_clear got=%0b/%0b/%b/%0d exp=0", collision, jumpCollision, HitEdgeCode, hitPixelCount); end
        drive(120, 135, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (collision !== 1'b0 || hitPixelCount !== 12'd0) begin
            failures++; $display("FAIL endgame_arm got=%0b/%0d exp=0/0", collision, hitPixelCount); end
        drive(120, 135, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (collision !== 1'b1 || hitPixelCount !== 12'd1) begin
            failures++; $display("FAIL endgame_next got=%0b/%0d exp=1/1", collision, hitPixelCount); end
    endtask

    task automatic test_filter();
        sof();
        for (int x = 115; x <= 116; x++) drive(x, 135, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (HitEdgeCode !== (FILT ? 4'b0000 : 4'b0001)) begin
            failures++; $display("FAIL filter_two got=%b exp=%b", HitEdgeCode, FILT ? 4'b0000 : 4'b0001); end
        checks++; if (collision !== 1'b1) begin failures++; $display("FAIL filter_collision got=%0b exp=1", collision); end
        for (int x = 115; x <= 117; x++) drive(x, 135, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (HitEdgeCode !== 4'b0001) begin failures++; $display("FAIL filter_three got=%b exp=0001", HitEdgeCode); end
    endtask

    task automatic test_reset_midframe();
        drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 resetN = 1'b0;
        #1;
        checks++; if ({collision, jumpCollision, HitEdgeCode, hitPixelCount} !== 18'd0) begin
            failures++; $display("FAIL midreset_clear got=%0b/%b/%0d exp=0", collision, HitEdgeCode, hitPixelCount); end
        @(posedge clk); #1;
        resetN = 1'b1;
        drive(120, 120, 1'b1, 1'b1, 1'b0, 1'b0);
        sof();
        checks++; if (collision !== 1'b0) begin failures++; $display("FAIL midreset_arm got=%0b exp=0", collision); end
        sof();
        checks++; if (collision !== 1'b0 || hitPixelCount !== 12'd0) begin
            failures++; $display("FAIL midreset_empty got=%0b/%0d exp=0/0", collision, hitPixelCount); end
    endtask

    initial begin
        test_reset();
        test_bottom_landing();
        test_corner();
        test_jump();
        test_sof_coincidence();
        test_negative_topleft();
        test_saturation();
        test_endgame();
        test_filter();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
